// File: rtl/ram_16x8_loader.sv
// 16x8 register file with a byte-stream loader (IDLE/LOAD/DONE) and a run-mode single-word write port.
// Words are plain registers, so the downstream 16:1 mux sees them with no added latency.
module ram_16x8_loader #(
   parameter int unsigned CLEAR_ON_START = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       prog,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic [7:0] word0,
   output logic [7:0] word1,
   output logic [7:0] word2,
   output logic [7:0] word3,
   output logic [7:0] word4,
   output logic [7:0] word5,
   output logic [7:0] word6,
   output logic [7:0] word7,
   output logic [7:0] word8,
   output logic [7:0] word9,
   output logic [7:0] word10,
   output logic [7:0] word11,
   output logic [7:0] word12,
   output logic [7:0] word13,
   output logic [7:0] word14,
   output logic [7:0] word15,
   output logic [3:0] load_addr,
   output logic       full
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e     r_state;
   state_e     w_state_d;
   logic [7:0] r_mem [16];
   logic [7:0] w_mem_d [16];
   logic [3:0] r_load_addr;
   logic [3:0] w_load_addr_d;
   logic       r_full;
   logic       w_full_d;

   always_comb begin
      w_state_d     = r_state;
      w_mem_d       = r_mem;
      w_load_addr_d = r_load_addr;
      w_full_d      = r_full;
      unique case (r_state)
         StIdle: begin
            // Program entry takes precedence over a run-mode write in the same cycle.
            if (prog) begin
               w_state_d     = StLoad;
               w_load_addr_d = 4'd0;
               w_full_d      = 1'b0;
               if (CLEAR_ON_START != 0) begin
                  for (int i = 0; i < 16; i++) begin
                     w_mem_d[i] = 8'h00;
                  end
               end
            end else if (wr_en) begin
               w_mem_d[wr_addr] = wr_data;
            end
         end
         StLoad: begin
            if (!prog) begin
               w_state_d = StIdle;
            end else if (in_valid) begin
               w_mem_d[r_load_addr] = in_data;
               w_load_addr_d        = r_load_addr + 4'd1;
               if (r_load_addr == 4'd15) begin
                  w_state_d = StDone;
                  w_full_d  = 1'b1;
               end
            end
         end
         StDone: begin
            if (!prog) begin
               w_state_d = StIdle;
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_load_addr <= 4'd0;
         r_full      <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            r_mem[i] <= 8'h00;
         end
      end else begin
         r_state     <= w_state_d;
         r_load_addr <= w_load_addr_d;
         r_full      <= w_full_d;
         r_mem       <= w_mem_d;
      end
   end

   assign in_ready  = (r_state == StLoad);
   assign load_addr = r_load_addr;
   assign full      = r_full;

   assign word0  = r_mem[0];
   assign word1  = r_mem[1];
   assign word2  = r_mem[2];
   assign word3  = r_mem[3];
   assign word4  = r_mem[4];
   assign word5  = r_mem[5];
   assign word6  = r_mem[6];
   assign word7  = r_mem[7];
   assign word8  = r_mem[8];
   assign word9  = r_mem[9];
   assign word10 = r_mem[10];
   assign word11 = r_mem[11];
   assign word12 = r_mem[12];
   assign word13 = r_mem[13];
   assign word14 = r_mem[14];
   assign word15 = r_mem[15];

endmodule

// File: doc/ram_16x8_loader.md
RAM_16X8_LOADER -- requirements
Module: ram_16x8_loader

Interface
REQ-001 SHALL have parameter: CLEAR_ON_START, default 1, when 1 all words are zeroed on entry to LOAD.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: prog  input  1  program-mode request (level).
REQ-005 SHALL have port: in_valid  input  1  loader byte valid.
REQ-006 SHALL have port: in_data  input  8  loader byte.
REQ-007 SHALL have port: in_ready  output  1  loader accepts byte this cycle.
REQ-008 SHALL have port: wr_en  input  1  run-mode single-word write strobe.
REQ-009 SHALL have port: wr_addr  input  4  run-mode write address.
REQ-010 SHALL have port: wr_data  input  8  run-mode write data.
REQ-011 SHALL have ports: word0 .. word15  output  8 each  stored words, wired directly to in0..in15 of the downstream 16-line 8-bit mux.
REQ-012 SHALL have port: load_addr  output  4  next address the loader will write.
REQ-013 SHALL have port: full  output  1  all 16 words loaded in current session.

Function
REQ-014 SHALL implement FSM with states IDLE, LOAD, DONE; all outputs registered or decoded from registered state only.
REQ-015 SHALL, in IDLE with prog=1, transition to LOAD next cycle, set load_addr=0, full=0, and zero all words if CLEAR_ON_START=1.
REQ-016 SHALL drive in_ready=1 only in LOAD; 0 in IDLE and DONE.
REQ-017 SHALL, in LOAD, on in_valid=1 with in_ready=1, write in_data to word[load_addr] and increment load_addr (mod 16) on that edge.
REQ-018 SHALL, on the accepted write at load_addr=15, transition to DONE, set full=1, and wrap load_addr to 0.
REQ-019 SHALL, in LOAD with in_valid=0, hold all state (no timeout).
REQ-020 SHALL, in LOAD with prog=0, abort to IDLE next cycle, keep words already written, keep full=0; a byte presented in that cycle is not written.
REQ-021 SHALL, in DONE, hold words and full=1 until prog=0, then return to IDLE with full still 1.
REQ-022 SHALL, in IDLE with prog=0 and wr_en=1, write wr_data to word[wr_addr] on the edge; one-cycle latency to wordN output.
REQ-023 SHALL ignore wr_en in LOAD and DONE, and ignore wr_en in the IDLE cycle where prog=1 (program entry wins).
REQ-024 SHALL present stored words combinationally stable between edges so the downstream mux output equals word[sel] with zero added latency.
REQ-025 SHALL clear full on next entry to LOAD; full otherwise sticky.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, regardless of state or prog, set state=IDLE, word0..word15=0, load_addr=0, full=0, in_ready=0.
REQ-027 SHALL give rst priority over every load, write and state transition in the same cycle, including mid-LOAD.
REQ-028 SHALL, after rst deasserts with prog held 1, enter LOAD on the first following edge.

Verification
REQ-029 SHALL cover: rst, then prog=1, stream bytes 0x10..0x1F with in_valid=1 every cycle -> in_ready=1 for 16 cycles, wordN=0x10+N, full=1, state DONE, in_ready=0.
REQ-030 SHALL cover: load with in_valid toggling 1/0 each cycle -> exactly 16 accepted writes over 32 cycles, same final words as continuous case.
REQ-031 SHALL cover: abort after 5 bytes (0xA0..0xA4) by prog=0 -> word0..4=0xA0..0xA4, word5..15=0, full=0, load_addr=5, IDLE.
REQ-032 SHALL cover: IDLE, wr_en=1, wr_addr=9, wr_data=0x5A -> word9=0x5A next cycle, others unchanged; repeated with prog=1 same cycle -> word9 not written, LOAD entered, all words 0.
REQ-033 SHALL cover: rst=1 asserted at load_addr=7 with in_valid=1 -> all words 0, load_addr=0, full=0, in_ready=0 next cycle.
REQ-034 SHALL cover: after full load 0x00..0x0F, sweep downstream mux sel 0..15 -> mux out equals sel.
